// File: rtl/router_pkg.sv
// Shared router definitions: header layout, reader FSM states and router timing constants.
package router_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned HDR_ADDR_LSB   = 0;
  localparam int unsigned HDR_ADDR_MSB   = 1;
  localparam int unsigned HDR_LEN_LSB    = 2;
  localparam int unsigned HDR_LEN_MSB    = DATA_W_DEF - 1;

  // Router soft-resets a port whose non-empty FIFO goes unread for this many cycles.
  localparam int unsigned ROUTER_TIMEOUT = 29;
  localparam int unsigned DLY_W          = $clog2(ROUTER_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    RD_HDR,
    HDR_CAP,
    RD_BODY,
    DRAIN,
    DONE
  } rd_state_t;

endpackage

// File: rtl/router_parity_acc.sv
// Byte-wide XOR parity accumulator: clear, load with header, fold in payload, compare against parity byte.
module router_parity_acc #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              match_o
);

  logic [DATA_W-1:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= din_i;
    end else if (acc_i) begin
      acc_q <= acc_q ^ din_i;
    end
  end

  assign match_o = (acc_q == din_i);

endmodule

// File: rtl/router_out_reader.sv
// Destination-side reader for one router output port: drains the FIFO, parses header/payload/parity,
// presents payload bytes downstream and counts completed, erroneous and aborted packets.
module router_out_reader
  import router_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              soft_reset,
  input  logic              rx_ready,
  output logic              read_enb,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_data_valid,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [1:0]        pkt_addr,
  output logic [DATA_W-3:0] pkt_len,
  output logic              pkt_done,
  output logic              parity_err,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  abort_count
);

  localparam int unsigned LEN_W = DATA_W - 2;
  localparam int unsigned REM_W = DATA_W - 1;

  rd_state_t         state_q;
  logic [DLY_W-1:0]  dly_q;
  logic [REM_W-1:0]  rd_rem_q;
  logic [REM_W-1:0]  cap_rem_q;
  logic              rd_q;
  logic              first_q;
  logic              err_pend_q;

  logic [DATA_W-1:0] pkt_data_q;
  logic              pkt_data_valid_q;
  logic              pkt_sop_q;
  logic              pkt_eop_q;
  logic [1:0]        pkt_addr_q;
  logic [LEN_W-1:0]  pkt_len_q;
  logic              pkt_done_q;
  logic              parity_err_q;
  logic [CNT_W-1:0]  pkt_count_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [CNT_W-1:0]  abort_count_q;

  logic [LEN_W-1:0]  hdr_len;
  logic [1:0]        hdr_addr;
  logic              body_rd;
  logic              cap;
  logic              cap_parity;
  logic              cap_payload;
  logic              hdr_cap;
  logic              acc_clr;
  logic              par_match;

  always_comb begin
    read_enb = 1'b0;
    case (state_q)
      RD_HDR:  read_enb = vld_out;
      RD_BODY: read_enb = vld_out & rx_ready;
      default: read_enb = 1'b0;
    endcase
  end

  assign hdr_len  = data_out[DATA_W-1:HDR_LEN_LSB];
  assign hdr_addr = data_out[HDR_ADDR_MSB:HDR_ADDR_LSB];

  // rd_q marks that the FIFO byte on data_out this cycle belongs to a body read issued last cycle.
  assign body_rd     = (state_q == RD_BODY) && read_enb && !soft_reset;
  assign cap         = rd_q && !soft_reset;
  assign cap_parity  = cap && (cap_rem_q == REM_W'(1));
  assign cap_payload = cap && (cap_rem_q != REM_W'(1));
  assign hdr_cap     = (state_q == HDR_CAP) && !soft_reset;
  assign acc_clr     = soft_reset || (state_q == IDLE);

  router_parity_acc #(
    .DATA_W(DATA_W)
  ) u_parity (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (acc_clr),
    .load_i (hdr_cap),
    .acc_i  (cap_payload),
    .din_i  (data_out),
    .match_o(par_match)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      dly_q            <= '0;
      rd_rem_q         <= '0;
      cap_rem_q        <= '0;
      rd_q             <= 1'b0;
      first_q          <= 1'b0;
      err_pend_q       <= 1'b0;
      pkt_data_q       <= '0;
      pkt_data_valid_q <= 1'b0;
      pkt_sop_q        <= 1'b0;
      pkt_eop_q        <= 1'b0;
      pkt_addr_q       <= '0;
      pkt_len_q        <= '0;
      pkt_done_q       <= 1'b0;
      parity_err_q     <= 1'b0;
      pkt_count_q      <= '0;
      err_count_q      <= '0;
      abort_count_q    <= '0;
    end else begin
      pkt_data_valid_q <= 1'b0;
      pkt_sop_q        <= 1'b0;
      pkt_eop_q        <= 1'b0;
      pkt_done_q       <= 1'b0;
      parity_err_q     <= 1'b0;
      rd_q             <= body_rd;

      if (soft_reset) begin
        // Abort wins over any capture or completion landing on the same edge.
        state_q <= IDLE;
        if (state_q != IDLE) begin
          abort_count_q <= abort_count_q + CNT_W'(1);
        end
      end else begin
        if (cap_payload) begin
          pkt_data_q       <= data_out;
          pkt_data_valid_q <= 1'b1;
          pkt_sop_q        <= first_q;
          pkt_eop_q        <= (cap_rem_q == REM_W'(2));
          first_q          <= 1'b0;
          cap_rem_q        <= cap_rem_q - REM_W'(1);
        end
        if (cap_parity) begin
          err_pend_q <= !par_match;
          cap_rem_q  <= '0;
        end

        case (state_q)
          IDLE: begin
            if (vld_out) begin
              dly_q   <= '0;
              state_q <= (START_DELAY == 0) ? RD_HDR : DELAY;
            end
          end
          DELAY: begin
            if (dly_q == DLY_W'(START_DELAY - 1)) begin
              state_q <= RD_HDR;
            end else begin
              dly_q <= dly_q + DLY_W'(1);
            end
          end
          RD_HDR: begin
            if (vld_out) begin
              state_q <= HDR_CAP;
            end
          end
          HDR_CAP: begin
            pkt_addr_q <= hdr_addr;
            pkt_len_q  <= hdr_len;
            rd_rem_q   <= {1'b0, hdr_len} + REM_W'(1);
            cap_rem_q  <= {1'b0, hdr_len} + REM_W'(1);
            first_q    <= 1'b1;
            state_q    <= RD_BODY;
          end
          RD_BODY: begin
            if (read_enb) begin
              rd_rem_q <= rd_rem_q - REM_W'(1);
              if (rd_rem_q == REM_W'(1)) begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (cap_parity) begin
              state_q <= DONE;
            end
          end
          DONE: begin
            pkt_done_q   <= 1'b1;
            parity_err_q <= err_pend_q;
            pkt_count_q  <= pkt_count_q + CNT_W'(1);
            if (err_pend_q) begin
              err_count_q <= err_count_q + CNT_W'(1);
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pkt_data       = pkt_data_q;
  assign pkt_data_valid = pkt_data_valid_q;
  assign pkt_sop        = pkt_sop_q;
  assign pkt_eop        = pkt_eop_q;
  assign pkt_addr       = pkt_addr_q;
  assign pkt_len        = pkt_len_q;
  assign pkt_done       = pkt_done_q;
  assign parity_err     = parity_err_q;
  assign pkt_count      = pkt_count_q;
  assign err_count      = err_count_q;
  assign abort_count    = abort_count_q;

endmodule

// File: tb/tb_router_out_reader.sv
// Bench for router_out_reader: queue-based router FIFO, packet-level reference model, per-scenario tasks.
module tb_router_out_reader;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned SD1 = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          rst0, srst0, rdy0, vld0;
  logic [DW-1:0] dout0, pd0;
  logic          re0, pv0, sop0, eop0, done0, perr0;
  logic [1:0]    addr0;
  logic [DW-3:0] len0;
  logic [CW-1:0] pc0, ec0, ac0;

  logic          rst1, srst1, rdy1, vld1;
  logic [DW-1:0] dout1, pd1;
  logic          re1, pv1, sop1, eop1, done1, perr1;
  logic [1:0]    addr1;
  logic [DW-3:0] len1;
  logic [CW-1:0] pc1, ec1, ac1;

  router_out_reader #(.DATA_W(DW), .START_DELAY(0), .CNT_W(CW)) dut (
    .clock(clk), .reset(rst0), .vld_out(vld0), .data_out(dout0), .soft_reset(srst0),
    .rx_ready(rdy0), .read_enb(re0), .pkt_data(pd0), .pkt_data_valid(pv0), .pkt_sop(sop0),
    .pkt_eop(eop0), .pkt_addr(addr0), .pkt_len(len0), .pkt_done(done0), .parity_err(perr0),
    .pkt_count(pc0), .err_count(ec0), .abort_count(ac0)
  );

  router_out_reader #(.DATA_W(DW), .START_DELAY(SD1), .CNT_W(CW)) dut28 (
    .clock(clk), .reset(rst1), .vld_out(vld1), .data_out(dout1), .soft_reset(srst1),
    .rx_ready(rdy1), .read_enb(re1), .pkt_data(pd1), .pkt_data_valid(pv1), .pkt_sop(sop1),
    .pkt_eop(eop1), .pkt_addr(addr1), .pkt_len(len1), .pkt_done(done1), .parity_err(perr1),
    .pkt_count(pc1), .err_count(ec1), .abort_count(ac1)
  );

  // Router port FIFOs: read data appears one cycle after read_enb is sampled.
  logic [DW-1:0] fifo0[$];
  logic [DW-1:0] fifo1[$];

  always @(posedge clk) begin
    if (rst0) begin
      vld0  <= 1'b0;
      dout0 <= '0;
    end else begin
      if (re0 && fifo0.size() > 0) dout0 <= fifo0.pop_front();
      vld0 <= (fifo0.size() != 0);
    end
  end

  always @(posedge clk) begin
    if (rst1) begin
      vld1  <= 1'b0;
      dout1 <= '0;
    end else begin
      if (re1 && fifo1.size() > 0) dout1 <= fifo1.pop_front();
      vld1 <= (fifo1.size() != 0);
    end
  end

  // Observed traffic of the main instance.
  logic [DW+1:0] obs0[$];
  bit            dn0[$];
  int            rdcnt0 = 0;
  int            rd_on_done0 = 0;
  int            stray0 = 0;

  always @(negedge clk) begin
    if (!rst0) begin
      if (pv0) obs0.push_back({sop0, eop0, pd0});
      if (done0) dn0.push_back(perr0);
      if (re0) rdcnt0++;
      if (re0 && done0) rd_on_done0++;
      if ((sop0 || eop0) && !pv0) stray0++;
    end
  end

  // Reference model: expected payload stream {sop,eop,byte}, parity verdicts and counters.
  logic [DW-1:0] pl[$];
  logic [DW+1:0] exp0[$];
  bit            expdn0[$];
  int            exp_pkt = 0, exp_err = 0, exp_abort = 0;

  function automatic logic [DW-1:0] good_par(input logic [DW-1:0] hdr);
    logic [DW-1:0] p = hdr;
    foreach (pl[i]) p ^= pl[i];
    return p;
  endfunction

  task automatic send_pkt0(input logic [DW-1:0] hdr, input logic [DW-1:0] par);
    int n = pl.size();
    bit bad = (par != good_par(hdr));
    fifo0.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      fifo0.push_back(pl[i]);
      exp0.push_back({(i == 0), (i == n - 1), pl[i]});
    end
    fifo0.push_back(par);
    expdn0.push_back(bad);
    exp_pkt++;
    if (bad) exp_err++;
  endtask

  task automatic fill_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(DW'($urandom_range(0, 255)));
  endtask

  task automatic wait_done0(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (dn0.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; srst0 = 1'b0; srst1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({re0, pv0, sop0, eop0, done0, perr0, addr0, len0, pd0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs0: got %h, want 0", {re0, pv0, sop0, eop0, done0, perr0, addr0, len0, pd0});
    end
    checks++;
    if ({pc0, ec0, ac0, pc1, ec1, ac1} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %h, want 0", {pc0, ec0, ac0, pc1, ec1, ac1});
    end
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({re0, re1, pv0, done0} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b, want 0000", {re0, re1, pv0, done0});
    end
  endtask

  task automatic test_basic();
    logic [DW+1:0] want[3] = '{10'h211, 10'h022, 10'h133};
    int ob = obs0.size();
    int tv = -1, tr = -1, k = 0;
    bit ok;
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt0(8'h0D, 8'h0D);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      k++;
      if (vld0 && tv < 0) tv = k;
      if (re0) begin
        tr = k;
        break;
      end
    end
    checks++;
    if (tv < 0 || tr - tv != 1) begin
      errors++;
      $display("FAIL first_read_latency0: got %0d, want 1", tr - tv);
    end
    wait_done0(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done: got no pkt_done, want one");
    end
    checks++;
    if (obs0.size() != ob + 3) begin
      errors++;
      $display("FAIL basic_count: got %0d bytes, want 3", obs0.size() - ob);
    end
    for (int i = 0; i < 3 && ob + i < obs0.size(); i++) begin
      checks++;
      if (obs0[ob + i] !== want[i]) begin
        errors++;
        $display("FAIL basic_byte[%0d]: got %h, want %h", i, obs0[ob + i], want[i]);
      end
    end
    checks++;
    if (dn0.size() < 1 || dn0[0] !== 1'b0 || pc0 !== CW'(1) || ec0 !== '0) begin
      errors++;
      $display("FAIL basic_status: got err=%0d pkts=%0d errs=%0d, want 0 1 0",
               (dn0.size() > 0) ? dn0[0] : 1'b1, pc0, ec0);
    end
    checks++;
    if (addr0 !== 2'd1 || len0 !== 6'd3) begin
      errors++;
      $display("FAIL basic_hdr: got addr=%0d len=%0d, want 1 3", addr0, len0);
    end
  endtask

  task automatic test_parity_err();
    bit ok;
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt0(8'h0D, 8'h00);
    wait_done0(2, ok);
    checks++;
    if (!ok || dn0[1] !== 1'b1) begin
      errors++;
      $display("FAIL parity_err_flag: got %0d, want 1", ok ? dn0[1] : 1'b0);
    end
    checks++;
    if (ec0 !== CW'(1) || pc0 !== CW'(2)) begin
      errors++;
      $display("FAIL parity_err_counts: got errs=%0d pkts=%0d, want 1 2", ec0, pc0);
    end
  endtask

  task automatic test_len0();
    int r = rdcnt0;
    int ob = obs0.size();
    bit ok;
    pl.delete();
    send_pkt0(8'h02, 8'h02);
    wait_done0(3, ok);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (!ok || rdcnt0 - r != 2) begin
      errors++;
      $display("FAIL len0_reads: got %0d read cycles, want 2", rdcnt0 - r);
    end
    checks++;
    if (obs0.size() != ob || stray0 != 0) begin
      errors++;
      $display("FAIL len0_strobes: got %0d data %0d stray, want 0 0", obs0.size() - ob, stray0);
    end
    checks++;
    if (!ok || dn0[2] !== 1'b0 || addr0 !== 2'd2 || len0 !== '0) begin
      errors++;
      $display("FAIL len0_status: got err=%0d addr=%0d len=%0d, want 0 2 0",
               ok ? dn0[2] : 1'b1, addr0, len0);
    end
  endtask

  task automatic test_rx_ready();
    int ob = obs0.size();
    int db = dn0.size();
    bit ok;
    logic [DW-1:0] hdr = {6'd8, 2'($urandom_range(0, 3))};
    fill_pl(8);
    send_pkt0(hdr, good_par(hdr));
    for (int i = 0; i < 100 && obs0.size() < ob + 2; i++) begin
      @(negedge clk); #1;
    end
    rdy0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if (re0 !== 1'b0) begin
        errors++;
        $display("FAIL rx_stall_read[%0d]: got %b, want 0", i, re0);
      end
      @(negedge clk); #1;
    end
    rdy0 = 1'b1;
    wait_done0(db + 1, ok);
    checks++;
    if (!ok || obs0.size() != ob + 8) begin
      errors++;
      $display("FAIL rx_stall_count: got %0d bytes, want 8", obs0.size() - ob);
    end
    for (int i = ob; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i] !== exp0[i]) begin
        errors++;
        $display("FAIL rx_stall_byte[%0d]: got %h, want %h", i - ob, obs0[i], exp0[i]);
      end
    end
  endtask

  task automatic test_soft_reset();
    int ob = obs0.size();
    int db = dn0.size();
    bit ok;
    logic [DW-1:0] hdr = {6'd5, 2'd3};
    fill_pl(5);
    fifo0.push_back(hdr);
    foreach (pl[i]) fifo0.push_back(pl[i]);
    fifo0.push_back(good_par(hdr));
    exp0.push_back({2'b10, pl[0]});
    exp0.push_back({2'b00, pl[1]});
    exp_abort++;
    for (int i = 0; i < 100 && obs0.size() < ob + 2; i++) begin
      @(negedge clk); #1;
    end
    srst0 = 1'b1;
    fifo0.delete();
    @(negedge clk); #1;
    srst0 = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (ac0 !== CW'(exp_abort)) begin
      errors++;
      $display("FAIL abort_count: got %0d, want %0d", ac0, exp_abort);
    end
    checks++;
    if (obs0.size() != ob + 2 || dn0.size() != db) begin
      errors++;
      $display("FAIL abort_quiet: got %0d bytes %0d done, want 2 0", obs0.size() - ob, dn0.size() - db);
    end
    hdr = {6'd4, 2'd0};
    fill_pl(4);
    send_pkt0(hdr, good_par(hdr));
    wait_done0(db + 1, ok);
    checks++;
    if (!ok || obs0.size() != exp0.size() || dn0[db] !== 1'b0) begin
      errors++;
      $display("FAIL after_abort_pkt: got %0d bytes, want %0d", obs0.size(), exp0.size());
    end
    for (int i = ob; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i] !== exp0[i]) begin
        errors++;
        $display("FAIL abort_byte[%0d]: got %h, want %h", i - ob, obs0[i], exp0[i]);
      end
    end
  endtask

  task automatic test_random_back_to_back();
    int ob = obs0.size();
    int db = dn0.size();
    bit ok = 1'b0;
    logic [DW-1:0] hdr = '0;
    logic [DW-1:0] par;
    for (int p = 0; p < 6; p++) begin
      fill_pl($urandom_range(0, 12));
      hdr = {6'(pl.size()), 2'($urandom_range(0, 3))};
      par = good_par(hdr);
      if ($urandom_range(0, 2) == 0) par ^= DW'($urandom_range(1, 255));
      send_pkt0(hdr, par);
    end
    for (int i = 0; i < 3000; i++) begin
      if (dn0.size() >= db + 6) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
      rdy0 = ($urandom_range(0, 3) != 0);
    end
    rdy0 = 1'b1;
    checks++;
    if (!ok || obs0.size() != exp0.size()) begin
      errors++;
      $display("FAIL random_count: got %0d bytes, want %0d", obs0.size(), exp0.size());
    end
    for (int i = ob; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i] !== exp0[i]) begin
        errors++;
        $display("FAIL random_byte[%0d]: got %h, want %h", i, obs0[i], exp0[i]);
      end
    end
    for (int i = db; i < expdn0.size() && i < dn0.size(); i++) begin
      checks++;
      if (dn0[i] !== expdn0[i]) begin
        errors++;
        $display("FAIL random_parity[%0d]: got %0d, want %0d", i, dn0[i], expdn0[i]);
      end
    end
    checks++;
    if (pc0 !== CW'(exp_pkt) || ec0 !== CW'(exp_err) || ac0 !== CW'(exp_abort)) begin
      errors++;
      $display("FAIL random_counters: got %0d/%0d/%0d, want %0d/%0d/%0d",
               pc0, ec0, ac0, exp_pkt, exp_err, exp_abort);
    end
    checks++;
    if (addr0 !== hdr[1:0] || len0 !== hdr[7:2]) begin
      errors++;
      $display("FAIL random_hdr_hold: got %0d/%0d, want %0d/%0d", addr0, len0, hdr[1:0], hdr[7:2]);
    end
    checks++;
    if (rd_on_done0 != 0 || stray0 != 0) begin
      errors++;
      $display("FAIL back_to_back_gap: got %0d reads on done, %0d stray, want 0 0", rd_on_done0, stray0);
    end
  endtask

  task automatic test_delay28();
    int tv = -1, tr = -1, k = 0;
    bit seen = 1'b0;
    fifo1.push_back({6'd4, 2'd3});
    for (int i = 0; i < 5; i++) fifo1.push_back(DW'($urandom_range(1, 255)));
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      k++;
      if (vld1 && tv < 0) tv = k;
      if (re1) begin
        tr = k;
        break;
      end
    end
    checks++;
    if (tv < 0 || tr - tv != SD1 + 1) begin
      errors++;
      $display("FAIL first_read_latency28: got %0d, want %0d", tr - tv, SD1 + 1);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = pv1;
    end
    rst1 = 1'b1;
    fifo1.delete();
    @(negedge clk); #1;
    checks++;
    if (!seen || {re1, pv1, sop1, eop1, done1, perr1, addr1, len1, pd1, pc1, ec1, ac1} !== '0) begin
      errors++;
      $display("FAIL midpkt_reset: got seen=%0d outs=%h, want 1 0", seen,
               {re1, pv1, sop1, eop1, done1, perr1, addr1, len1, pd1, pc1, ec1, ac1});
    end
    rst1 = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if ({re1, pv1, done1} !== 3'b0 || pc1 !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b cnt=%0d, want 000 0", {re1, pv1, done1}, pc1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_len0();
    test_rx_ready();
    test_soft_reset();
    test_random_back_to_back();
    test_delay28();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
